// File: rtl/wb_write_sequencer.sv
// Serialises up to two writeback writes per cycle plus an external requester
// onto a single register-file write port, with starvation protection for ext.
module wb_write_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_write,
    input  logic [4:0]  wb_wa1,
    input  logic [4:0]  wb_wa2,
    input  logic [31:0] wb_wr1,
    input  logic [31:0] wb_wr2,
    input  logic        ext_req,
    input  logic [4:0]  ext_wa,
    input  logic [31:0] ext_wd,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        ext_ack,
    output logic        stall
);

    typedef enum logic {IDLE = 1'b0, PEND2 = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [1:0]  starve_q, starve_d;
    logic [4:0]  buf_wa_q, buf_wa_d;
    logic [31:0] buf_wd_q, buf_wd_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_wa_q, rf_wa_d;
    logic [31:0] rf_wd_q, rf_wd_d;
    logic        ext_ack_q, ext_ack_d;
    logic        starved;

    assign starved = (starve_q == 2'd3) && ext_req;
    assign stall   = (state_q == PEND2) || starved;

    assign rf_we   = rf_we_q;
    assign rf_wa   = rf_wa_q;
    assign rf_wd   = rf_wd_q;
    assign ext_ack = ext_ack_q;

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        buf_wa_d  = buf_wa_q;
        buf_wd_d  = buf_wd_q;
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        ext_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ext_req && (starved || wb_write == 2'b00)) begin
                    rf_we_d   = 1'b1;
                    rf_wa_d   = ext_wa;
                    rf_wd_d   = ext_wd;
                    ext_ack_d = 1'b1;
                    starve_d  = 2'd0;
                end else if (wb_write != 2'b00) begin
                    rf_we_d = 1'b1;
                    if (wb_write[0]) begin
                        rf_wa_d = wb_wa1;
                        rf_wd_d = wb_wr1;
                    end else begin
                        rf_wa_d = wb_wa2;
                        rf_wd_d = wb_wr2;
                    end
                    // Dual write: slot1 now, slot2 parked for the next edge.
                    if (wb_write == 2'b11) begin
                        buf_wa_d = wb_wa2;
                        buf_wd_d = wb_wr2;
                        state_d  = PEND2;
                    end
                    if (!ext_req)
                        starve_d = 2'd0;
                    else if (starve_q != 2'd3)
                        starve_d = starve_q + 2'd1;
                end else begin
                    starve_d = 2'd0;
                end
            end
            PEND2: begin
                rf_we_d = 1'b1;
                rf_wa_d = buf_wa_q;
                rf_wd_d = buf_wd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            starve_q  <= 2'd0;
            buf_wa_q  <= 5'd0;
            buf_wd_q  <= 32'd0;
            rf_we_q   <= 1'b0;
            rf_wa_q   <= 5'd0;
            rf_wd_q   <= 32'd0;
            ext_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            buf_wa_q  <= buf_wa_d;
            buf_wd_q  <= buf_wd_d;
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
            ext_ack_q <= ext_ack_d;
        end
    end

endmodule

// File: doc/wb_write_sequencer.md
WB_WRITE_SEQUENCER -- requirements
Module: wb_write_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising-edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: wb_write  in  2  writeback write-enable bitmap (bit0 = slot1, bit1 = slot2).
REQ-003 SHALL have: wb_wa1, wb_wa2  in  5 each  slot1/slot2 destination register addresses.
REQ-004 SHALL have: wb_wr1, wb_wr2  in  32 each  slot1/slot2 write data.
REQ-005 SHALL have: ext_req  in  1  external requester write request, level, held until ext_ack.
REQ-006 SHALL have: ext_wa  in  5  and  ext_wd  in  32  external write address/data, stable while ext_req=1.
REQ-007 SHALL have: rf_we  out  1, rf_wa  out  5, rf_wd  out  32  single register-file write port, all registered.
REQ-008 SHALL have: ext_ack  out  1  one-cycle pulse, registered, coincident with the rf_we cycle of the ext write.
REQ-009 SHALL have: stall  out  1  combinational; when 1, upstream holds its writeback outputs and this block ignores wb_* inputs.

Function
REQ-010 SHALL implement FSM states IDLE and PEND2, plus a 2-bit starvation counter starve_cnt.
REQ-011 stall SHALL equal (state==PEND2) OR (starve_cnt==3 AND ext_req).
REQ-012 In IDLE with stall=0 at a clock edge, wb_write is sampled; each issued write appears on rf_* exactly one cycle later (latency 1).
REQ-013 wb_write=01: SHALL issue slot1 (rf_wa=wb_wa1, rf_wd=wb_wr1); state stays IDLE.
REQ-014 wb_write=10: SHALL issue slot2 only; state stays IDLE.
REQ-015 wb_write=11: SHALL issue slot1, latch wb_wa2/wb_wr2 into an internal buffer, go to PEND2.
REQ-016 PEND2: at the next edge SHALL issue the buffered slot2 write and return to IDLE; wb_* and ext_req ignored that edge.
REQ-017 Same address in both slots: slot1 written first, slot2 second; slot2 value SHALL be final.
REQ-018 IDLE, wb_write=00 (or stall=1 from starvation), ext_req=1: SHALL issue ext write and pulse ext_ack; starve_cnt cleared.
REQ-019 IDLE, wb_write!=00, stall=0, ext_req=1: wb wins; starve_cnt SHALL increment, saturating at 3.
REQ-020 starve_cnt SHALL clear whenever ext_req=0 or on ext grant; no change in PEND2.
REQ-021 At starve_cnt==3 with ext_req=1: stall forced high, ext granted at the next edge, wb inputs held by upstream and consumed the following cycle.
REQ-022 Cycles with no issue SHALL drive rf_we=0; rf_wa/rf_wd hold last values.
REQ-023 Writes to address 0 SHALL be issued unchanged; register-0 masking is the register file's job.
REQ-024 ext_ack SHALL never assert in the same cycle as a wb-originated rf_we.

Reset
REQ-025 On rst: state=IDLE, starve_cnt=0, buffer=0, rf_we=0, rf_wa=0, rf_wd=0, ext_ack=0; stall therefore 0.
REQ-026 rst mid-PEND2 SHALL discard the buffered slot2 write; nothing issued after reset release until new input.
REQ-027 First edge after rst deassertion SHALL process inputs normally.

Verification
REQ-028 wb_write=01, wa1=5, wr1=0xDEADBEEF -> next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF, stall=0.
REQ-029 wb_write=11, wa1=3/wr1=0x11, wa2=7/wr2=0x22 -> cycle+1: rf_wa=3, rf_wd=0x11, stall=1; cycle+2: rf_wa=7, rf_wd=0x22; stall=0 afterwards.
REQ-030 wb_write=11, wa1=wa2=9, wr1=0xA, wr2=0xB -> two writes to 9 in order 0xA, then 0xB.
REQ-031 ext_req=1 (wa=4, wd=0x55) with wb_write=00 -> next cycle rf_wa=4, rf_wd=0x55, ext_ack=1 for exactly one cycle.
REQ-032 ext_req=1 held with wb_write=01 every cycle -> three wb writes issued, stall=1, ext write issued 4th, ext_ack=1, then wb resumes.
REQ-033 rst asserted during PEND2 -> rf_we=0, stall=0 immediately; no slot2 write ever appears.
